match_judge: RTL and testbench
==============================

// Module: match_judge
// PURPOSE
//   Sequential best-of-ROUNDS judge for the two-player card game. Per round it accepts
//   one p1/p2 card pair and compares them as unsigned values. It keeps per-player scores
//   and ends the match early once a player holds a majority. Sits between the card-deal
//   logic and the score/LED display; generalises the 4-bit one-shot card compare.
// PARAMETERS
//   CARD_W   4   card value width in bits; cards are compared as unsigned values
//   ROUNDS   5   rounds in a regulation match (>=1); majority MAJ = ROUNDS/2+1
//   ROUND_W  4   width of the rounds_played counter; the counter saturates at 2^ROUND_W-1
//   Localparam SCORE_W = $clog2(ROUNDS+1).
// PORTS
//   clk           in   1        system clock, rising edge
//   reset         in   1        asynchronous reset, active-high
//   start         in   1        one-cycle pulse: begin a new match; honoured only in IDLE or DONE
//   card_valid    in   1        p1_card/p2_card hold a valid pair
//   p1_card       in   CARD_W   player 1 card value
//   p2_card       in   CARD_W   player 2 card value
//   card_ready    out  1        high only in WAIT; a pair is accepted when card_valid & card_ready
//   round_valid   out  1        one-cycle pulse: round_result is valid
//   round_result  out  2        00 none, 01 p1 wins round, 10 p2 wins round, 11 tie
//   p1_score      out  SCORE_W  rounds won by p1 in the current match
//   p2_score      out  SCORE_W  rounds won by p2 in the current match
//   rounds_played out  ROUND_W  rounds accepted so far, ties included
//   busy          out  1        high in WAIT and RESULT
//   match_done    out  1        level; high in DONE
//   winner        out  2        00 none, 01 p1, 10 p2, 11 drawn match; valid while match_done
// BEHAVIOUR
//   - Reset: all outputs 0 and state IDLE. Reset mid-match discards all scores; no partial result is kept.
//   - FSM: IDLE -start-> WAIT (scores, rounds_played, round_result and winner cleared).
//     WAIT -accept-> RESULT. RESULT -> DONE or WAIT. DONE -start-> WAIT (cleared).
//   - start in WAIT or RESULT is ignored.
//   - On the accept edge the block registers the following:
//     - round_result = 01 if p1>p2, 10 if p1<p2, 11 if equal;
//     - the winning player's score +1 (ties change no score);
//     - rounds_played +1.
//   - In RESULT: round_valid=1 for exactly one cycle. The termination check uses the updated values:
//     - p1_score==MAJ -> DONE with winner=01; p2_score==MAJ -> DONE with winner=10;
//     - else if rounds_played>=ROUNDS: the higher score wins; equal scores -> see CONFIGURATION;
//     - else -> WAIT.
//   - Throughput: at most one round per 2 cycles. card_ready is low in RESULT, so a
//     card_valid held high across RESULT is not re-counted until WAIT.
//   - DONE holds scores and winner stable until the next start or reset; round_result keeps its last value.
// CONFIGURATION
//   Macro SUDDEN_DEATH_EN.
//   - Undefined: equal scores after ROUNDS rounds -> DONE with winner=11.
//   - Defined: equal scores after ROUNDS rounds -> back to WAIT for extra rounds.
//     - The first decisive extra round ends the match, and its winner is the match winner.
//     - Tied extra rounds continue the match; rounds_played saturates and does not wrap.
// TESTING
//   1. Defaults; pairs (9,3),(12,7),(5,2) -> round_result 01 x3; after round 3 match_done=1,
//      winner=01, p1_score=3, p2_score=0, rounds_played=3; card_ready stays 0.
//   2. Pair (7,7) -> round_result=11, scores unchanged, rounds_played+1, busy stays 1.
//   3. Pairs (1,2),(3,1),(4,4),(0,15),(15,0) -> scores 2-2 after 5 rounds.
//      - Without SUDDEN_DEATH_EN: winner=11.
//      - With SUDDEN_DEATH_EN: (6,6) keeps busy=1; then (6,8) -> winner=10, p2_score=3, rounds_played=7.
//   4. card_valid held high for 6 cycles with pair (5,1) -> exactly 3 accepts, spaced 2 cycles apart.
//      One round_valid pulse per accept; p1_score=3, winner=01.
//   5. Scores 1-1 after 2 rounds -> start pulse ignored.
//      Then reset asserted mid-RESULT -> all outputs 0 immediately; the FSM restarts from IDLE.
//   6. CARD_W=8, ROUNDS=1: start, pair (200,199) -> round_result=01, match_done=1, winner=01.
//      Then start -> scores=0, busy=1.

Source files
------------

// File: rtl/match_judge.sv
// Best-of-ROUNDS two-player card judge: one unsigned p1/p2 compare per accepted pair, early finish on majority.
// Optional SUDDEN_DEATH_EN: a level match after ROUNDS rounds continues until the first decisive round.
module match_judge #(
  parameter int CARD_W  = 4,
  parameter int ROUNDS  = 5,
  parameter int ROUND_W = 4,
  localparam int SCORE_W = $clog2(ROUNDS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               card_valid,
  input  logic [CARD_W-1:0]  p1_card,
  input  logic [CARD_W-1:0]  p2_card,
  output logic               card_ready,
  output logic               round_valid,
  output logic [1:0]         round_result,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [ROUND_W-1:0] rounds_played,
  output logic               busy,
  output logic               match_done,
  output logic [1:0]         winner
);

  localparam logic [SCORE_W-1:0] MAJ      = SCORE_W'(ROUNDS / 2 + 1);
  localparam logic [ROUND_W-1:0] ROUNDS_C = ROUND_W'(ROUNDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESULT, DONE} state_t;

  state_t             state, state_nxt;
  logic [1:0]         round_result_nxt, winner_nxt;
  logic [SCORE_W-1:0] p1_score_nxt, p2_score_nxt;
  logic [ROUND_W-1:0] rounds_nxt;
  logic               accept;

  assign card_ready  = (state == WAIT);
  assign round_valid = (state == RESULT);
  assign busy        = (state == WAIT) || (state == RESULT);
  assign match_done  = (state == DONE);
  assign accept      = card_valid & card_ready;

  always_comb begin
    state_nxt        = state;
    round_result_nxt = round_result;
    winner_nxt       = winner;
    p1_score_nxt     = p1_score;
    p2_score_nxt     = p2_score;
    rounds_nxt       = rounds_played;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt        = WAIT;
          round_result_nxt = 2'b00;
          winner_nxt       = 2'b00;
          p1_score_nxt     = '0;
          p2_score_nxt     = '0;
          rounds_nxt       = '0;
        end
      end
      WAIT: begin
        if (accept) begin
          state_nxt = RESULT;
          if (p1_card > p2_card) begin
            round_result_nxt = 2'b01;
            p1_score_nxt     = p1_score + SCORE_W'(1);
          end else if (p1_card < p2_card) begin
            round_result_nxt = 2'b10;
            p2_score_nxt     = p2_score + SCORE_W'(1);
          end else begin
            round_result_nxt = 2'b11;
          end
          // Saturate so long sudden-death runs never wrap back to zero.
          if (rounds_played != '1)
            rounds_nxt = rounds_played + ROUND_W'(1);
        end
      end
      RESULT: begin
        // Registered scores already include the round just accepted.
        if (p1_score == MAJ) begin
          state_nxt  = DONE;
          winner_nxt = 2'b01;
        end else if (p2_score == MAJ) begin
          state_nxt  = DONE;
          winner_nxt = 2'b10;
        end else if (rounds_played >= ROUNDS_C) begin
          if (p1_score > p2_score) begin
            state_nxt  = DONE;
            winner_nxt = 2'b01;
          end else if (p2_score > p1_score) begin
            state_nxt  = DONE;
            winner_nxt = 2'b10;
          end else begin
`ifdef SUDDEN_DEATH_EN
            state_nxt  = WAIT;
`else
            state_nxt  = DONE;
            winner_nxt = 2'b11;
`endif
          end
        end else begin
          state_nxt = WAIT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      round_result  <= 2'b00;
      winner        <= 2'b00;
      p1_score      <= '0;
      p2_score      <= '0;
      rounds_played <= '0;
    end else begin
      state         <= state_nxt;
      round_result  <= round_result_nxt;
      winner        <= winner_nxt;
      p1_score      <= p1_score_nxt;
      p2_score      <= p2_score_nxt;
      rounds_played <= rounds_nxt;
    end
  end

endmodule

// File: tb/tb_match_judge.sv
// Directed bench for match_judge: default 4-bit/5-round instance plus an 8-bit/1-round instance.
module tb_match_judge;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       card_valid = 1'b0;
  logic [3:0] p1_card = '0, p2_card = '0;
  logic       card_ready, round_valid, busy, match_done;
  logic [1:0] round_result, winner;
  logic [2:0] p1_score, p2_score;
  logic [3:0] rounds_played;

  logic       s_start = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_p1 = '0, s_p2 = '0;
  logic       s_ready, s_rvalid, s_busy, s_done;
  logic [1:0] s_result, s_winner;
  logic       s_p1s, s_p2s;
  logic [3:0] s_rounds;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  match_judge u0 (
    .clk(clk), .reset(reset), .start(start), .card_valid(card_valid),
    .p1_card(p1_card), .p2_card(p2_card), .card_ready(card_ready),
    .round_valid(round_valid), .round_result(round_result), .p1_score(p1_score),
    .p2_score(p2_score), .rounds_played(rounds_played), .busy(busy),
    .match_done(match_done), .winner(winner)
  );

  match_judge #(.CARD_W(8), .ROUNDS(1), .ROUND_W(4)) u1 (
    .clk(clk), .reset(reset), .start(s_start), .card_valid(s_valid),
    .p1_card(s_p1), .p2_card(s_p2), .card_ready(s_ready),
    .round_valid(s_rvalid), .round_result(s_result), .p1_score(s_p1s),
    .p2_score(s_p2s), .rounds_played(s_rounds), .busy(s_busy),
    .match_done(s_done), .winner(s_winner)
  );

  function automatic logic [17:0] u0_outs();
    return {card_ready, round_valid, round_result, p1_score, p2_score,
            rounds_played, busy, match_done, winner};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Present one pair and return just after the accept edge (DUT then in RESULT).
  task automatic play(input logic [3:0] a, input logic [3:0] b);
    int n = 0;
    while (!card_ready && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (card_ready !== 1'b1) begin
      errors++;
      $display("FAIL play_wait_ready: card_ready=%b after %0d cycles, required 1", card_ready, n);
    end
    card_valid = 1'b1;
    p1_card    = a;
    p2_card    = b;
    step();
    card_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (u0_outs() !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", u0_outs());
    end
    checks++;
    if ({s_ready, s_rvalid, s_result, s_p1s, s_p2s, s_rounds, s_busy, s_done, s_winner} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs_small: nonzero output on small instance");
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_p1_sweep();
    logic [3:0] a [3] = '{4'd9, 4'd12, 4'd5};
    logic [3:0] b [3] = '{4'd3, 4'd7, 4'd2};
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      play(a[i], b[i]);
      checks++;
      if (round_valid !== 1'b1 || round_result !== 2'b01) begin
        errors++;
        $display("FAIL sweep_round%0d: round_valid=%b result=%b, required 1/01", i, round_valid, round_result);
      end
    end
    step();
    checks++;
    if ({match_done, winner, p1_score, p2_score, rounds_played, card_ready, busy}
        !== {1'b1, 2'b01, 3'd3, 3'd0, 4'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sweep_done: done=%b winner=%b p1=%0d p2=%0d rounds=%0d ready=%b busy=%b, required 1 01 3 0 3 0 0",
               match_done, winner, p1_score, p2_score, rounds_played, card_ready, busy);
    end
    step();
    checks++;
    if (card_ready !== 1'b0 || match_done !== 1'b1) begin
      errors++;
      $display("FAIL sweep_hold: ready=%b done=%b, required 0 1", card_ready, match_done);
    end
  endtask

  task automatic test_tie();
    pulse_start();
    play(4'd7, 4'd7);
    checks++;
    if ({round_result, p1_score, p2_score, rounds_played, busy} !== {2'b11, 3'd0, 3'd0, 4'd1, 1'b1}) begin
      errors++;
      $display("FAIL tie_round: result=%b p1=%0d p2=%0d rounds=%0d busy=%b, required 11 0 0 1 1",
               round_result, p1_score, p2_score, rounds_played, busy);
    end
    step();
    checks++;
    if (busy !== 1'b1 || card_ready !== 1'b1 || match_done !== 1'b0) begin
      errors++;
      $display("FAIL tie_continue: busy=%b ready=%b done=%b, required 1 1 0", busy, card_ready, match_done);
    end
    pulse_reset();
  endtask

  task automatic test_split();
    logic [3:0] a [5] = '{4'd1, 4'd3, 4'd4, 4'd0, 4'd15};
    logic [3:0] b [5] = '{4'd2, 4'd1, 4'd4, 4'd15, 4'd0};
    logic [1:0] r [5] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b01};
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      play(a[i], b[i]);
      checks++;
      if (round_result !== r[i]) begin
        errors++;
        $display("FAIL split_round%0d: result=%b, required %b", i, round_result, r[i]);
      end
      step();
    end
    checks++;
    if ({p1_score, p2_score, rounds_played} !== {3'd2, 3'd2, 4'd5}) begin
      errors++;
      $display("FAIL split_scores: p1=%0d p2=%0d rounds=%0d, required 2 2 5", p1_score, p2_score, rounds_played);
    end
`ifdef SUDDEN_DEATH_EN
    checks++;
    if (busy !== 1'b1 || match_done !== 1'b0) begin
      errors++;
      $display("FAIL sd_continue: busy=%b done=%b, required 1 0", busy, match_done);
    end
    play(4'd6, 4'd6);
    step();
    checks++;
    if (busy !== 1'b1 || match_done !== 1'b0 || rounds_played !== 4'd6) begin
      errors++;
      $display("FAIL sd_tie: busy=%b done=%b rounds=%0d, required 1 0 6", busy, match_done, rounds_played);
    end
    play(4'd6, 4'd8);
    step();
    checks++;
    if ({match_done, winner, p2_score, rounds_played} !== {1'b1, 2'b10, 3'd3, 4'd7}) begin
      errors++;
      $display("FAIL sd_decide: done=%b winner=%b p2=%0d rounds=%0d, required 1 10 3 7",
               match_done, winner, p2_score, rounds_played);
    end
`else
    checks++;
    if (match_done !== 1'b1 || winner !== 2'b11) begin
      errors++;
      $display("FAIL split_draw: done=%b winner=%b, required 1 11", match_done, winner);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int first = -1;
    int last = -1;
    int gap_bad = 0;
    pulse_start();
    card_valid = 1'b1;
    p1_card    = 4'd5;
    p2_card    = 4'd1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (round_valid) begin
        if (first < 0) first = i;
        if (last >= 0 && i - last != 2) gap_bad++;
        last = i;
        pulses++;
      end
    end
    card_valid = 1'b0;
    checks++;
    if (pulses !== 3 || gap_bad !== 0 || first !== 0) begin
      errors++;
      $display("FAIL b2b_accepts: pulses=%0d first=%0d bad_gaps=%0d, required 3 0 0", pulses, first, gap_bad);
    end
    checks++;
    if ({p1_score, rounds_played, match_done, winner} !== {3'd3, 4'd3, 1'b1, 2'b01}) begin
      errors++;
      $display("FAIL b2b_final: p1=%0d rounds=%0d done=%b winner=%b, required 3 3 1 01",
               p1_score, rounds_played, match_done, winner);
    end
  endtask

  task automatic test_start_and_reset();
    pulse_start();
    play(4'd1, 4'd2);
    step();
    play(4'd3, 4'd1);
    step();
    pulse_start();
    checks++;
    if ({p1_score, p2_score, rounds_played, busy, card_ready} !== {3'd1, 3'd1, 4'd2, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL start_ignored: p1=%0d p2=%0d rounds=%0d busy=%b ready=%b, required 1 1 2 1 1",
               p1_score, p2_score, rounds_played, busy, card_ready);
    end
    play(4'd9, 4'd4);
    checks++;
    if (round_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre: round_valid=%b, required 1", round_valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (u0_outs() !== 18'd0) begin
      errors++;
      $display("FAIL reset_async: got %h, required 0", u0_outs());
    end
    step();
    reset = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || match_done !== 1'b0 || card_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b done=%b ready=%b, required 0 0 0", busy, match_done, card_ready);
    end
    pulse_start();
    checks++;
    if (busy !== 1'b1 || rounds_played !== 4'd0 || p1_score !== 3'd0) begin
      errors++;
      $display("FAIL reset_restart: busy=%b rounds=%0d p1=%0d, required 1 0 0", busy, rounds_played, p1_score);
    end
  endtask

  task automatic test_single_round();
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    s_valid = 1'b1;
    s_p1    = 8'd200;
    s_p2    = 8'd199;
    step();
    s_valid = 1'b0;
    checks++;
    if (s_rvalid !== 1'b1 || s_result !== 2'b01) begin
      errors++;
      $display("FAIL small_round: round_valid=%b result=%b, required 1 01", s_rvalid, s_result);
    end
    step();
    checks++;
    if (s_done !== 1'b1 || s_winner !== 2'b01 || s_p1s !== 1'b1) begin
      errors++;
      $display("FAIL small_done: done=%b winner=%b p1=%0d, required 1 01 1", s_done, s_winner, s_p1s);
    end
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    checks++;
    if ({s_p1s, s_p2s, s_busy, s_winner} !== {1'b0, 1'b0, 1'b1, 2'b00}) begin
      errors++;
      $display("FAIL small_restart: p1=%0d p2=%0d busy=%b winner=%b, required 0 0 1 00",
               s_p1s, s_p2s, s_busy, s_winner);
    end
  endtask

  initial begin
    test_reset();
    test_p1_sweep();
    test_tie();
    test_split();
    test_back_to_back();
    test_start_and_reset();
    test_single_round();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
